// File: rtl/eth_rx_frame_parser.sv
// eth_rx_frame_parser: RX FIFO header parse, DA filter, length/sum status per frame; RX_STATS_EN adds stat_clr, good_cnt, bad_cnt
module eth_rx_frame_parser #(
  parameter logic [47:0] LOCAL_MAC = 48'h002b67b52e46,
  parameter bit PROMISC = 1'b0,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ff_rx_data,
  input  logic        ff_rx_dval,
  input  logic        ff_rx_sop,
  input  logic        ff_rx_eop,
  input  logic [1:0]  ff_rx_mod,
  input  logic [5:0]  rx_err,
  output logic        ff_rx_rdy,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [4:0]  frame_status,
  output logic [47:0] rx_dst_mac,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_len_type,
  output logic [10:0] rx_payload_len,
  output logic [15:0] rx_payload_sum
`ifdef RX_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
  localparam logic [11:0] MAX_B = 12'(MAX_FRAME_BYTES);
  state_t state_q, state_d;
  logic [1:0] widx_q, widx_d;
  logic [47:0] da_q, da_d, sa_q, sa_d, w_da, w_sa, r_da, r_sa, da_full;
  logic [15:0] lt_q, lt_d, sum_q, sum_d, w_lt, w_sum, r_lt, r_sum;
  logic [11:0] cnt_q, cnt_d, w_cnt, r_cnt, cnt_b;
  logic err_q, err_d, miss_q, miss_d, long_q, long_d, rdy_q;
  logic w_err, w_miss, w_long, acc, bad, hit;
  logic rep, r_abort, r_runt, r_err, r_miss, r_long;
  logic [4:0] r_status;
  logic [31:0] dw;
  assign acc = ff_rx_dval & rdy_q;
  assign bad = |rx_err;
  assign ff_rx_rdy = rdy_q;
  assign cnt_b = cnt_q + 12'd4;
  assign da_full = {da_q[47:16], ff_rx_data[31:16]};
  assign hit = PROMISC || da_full == LOCAL_MAC || &da_full;
  assign dw = ff_rx_data & (!ff_rx_eop || ff_rx_mod == 2'd0 ? 32'hffffffff :
                            ff_rx_mod == 2'd1 ? 32'hffffff00 :
                            ff_rx_mod == 2'd2 ? 32'hffff0000 : 32'hff000000);
  assign r_status = {r_abort, r_miss, r_err, r_long, r_runt};
  always_comb begin
    w_da = da_q;
    w_sa = sa_q;
    w_lt = lt_q;
    w_sum = sum_q;
    w_err = err_q | bad;
    w_miss = miss_q;
    w_cnt = state_q == DROP ? cnt_q : cnt_b - (ff_rx_eop ? {10'd0, ff_rx_mod} : 12'd0);
    if (state_q == HDR && widx_q == 2'd1) begin
      w_da[15:0] = ff_rx_data[31:16];
      w_sa[47:32] = ff_rx_data[15:0];
      w_miss = !hit;
    end
    if (state_q == HDR && widx_q == 2'd2) w_sa[31:0] = ff_rx_data;
    if (state_q == HDR && widx_q == 2'd3) begin
      w_lt = ff_rx_data[31:16];
      w_sum = sum_q + dw[15:0];
    end
    if (state_q == PAYLOAD) w_sum = sum_q + dw[31:16] + dw[15:0];
    w_long = long_q | (state_q != DROP && w_cnt > MAX_B);
  end
  always_comb begin
    state_d = state_q;
    widx_d = widx_q;
    da_d = da_q;
    sa_d = sa_q;
    lt_d = lt_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    err_d = err_q;
    miss_d = miss_q;
    long_d = long_q;
    rep = 1'b0;
    r_abort = 1'b0;
    r_runt = 1'b0;
    r_da = w_da;
    r_sa = w_sa;
    r_lt = w_lt;
    r_cnt = w_cnt;
    r_sum = w_sum;
    r_err = w_err;
    r_miss = w_miss;
    r_long = w_long;
    if (acc && state_q != IDLE && !ff_rx_sop) begin
      {da_d, sa_d, lt_d, cnt_d, sum_d} = {w_da, w_sa, w_lt, w_cnt, w_sum};
      {err_d, miss_d, long_d} = {w_err, w_miss, w_long};
      widx_d = widx_q + 2'd1;
      state_d = ff_rx_eop ? IDLE :
                state_q == HDR && widx_q == 2'd3 ? PAYLOAD :
                state_q == PAYLOAD && w_long ? DROP : state_q;
      rep = ff_rx_eop;
      r_runt = (state_q == HDR && widx_q != 2'd3) || w_cnt < 12'd14;
    end
    if (acc && state_q != IDLE && ff_rx_sop) begin
      rep = 1'b1;
      r_abort = 1'b1;
      {r_da, r_sa, r_lt, r_cnt, r_sum} = {da_q, sa_q, lt_q, cnt_q, sum_q};
      {r_err, r_miss, r_long} = {err_q, miss_q, long_q};
    end
    if (acc && ff_rx_sop) begin
      da_d = {ff_rx_data, 16'h0};
      sa_d = 48'h0;
      lt_d = 16'h0;
      cnt_d = 12'd4;
      sum_d = 16'h0;
      err_d = bad;
      miss_d = 1'b0;
      long_d = 1'b0;
      widx_d = 2'd1;
      state_d = ff_rx_eop ? IDLE : HDR;
      if (state_q == IDLE && ff_rx_eop) begin
        rep = 1'b1;
        r_runt = 1'b1;
        {r_da, r_sa, r_lt, r_cnt, r_sum} = {ff_rx_data, 16'h0, 48'h0, 16'h0, 12'd4, 16'h0};
        {r_err, r_miss, r_long} = {bad, 1'b0, 1'b0};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      widx_q <= 2'd0;
      {da_q, sa_q, lt_q, cnt_q, sum_q} <= '0;
      {err_q, miss_q, long_q, rdy_q} <= '0;
      {frame_done, frame_ok, frame_status} <= '0;
      {rx_dst_mac, rx_src_mac, rx_len_type, rx_payload_len, rx_payload_sum} <= '0;
    end else begin
      state_q <= state_d;
      widx_q <= widx_d;
      {da_q, sa_q, lt_q, cnt_q, sum_q} <= {da_d, sa_d, lt_d, cnt_d, sum_d};
      {err_q, miss_q, long_q} <= {err_d, miss_d, long_d};
      rdy_q <= 1'b1;
      frame_done <= rep;
      if (rep) begin
        frame_ok <= r_status == 5'd0;
        frame_status <= r_status;
        rx_dst_mac <= r_da;
        rx_src_mac <= r_sa;
        rx_len_type <= r_lt;
        rx_payload_len <= r_runt || r_cnt < 12'd14 ? 11'd0 : 11'(r_cnt - 12'd14);
        rx_payload_sum <= r_runt ? 16'h0 : r_sum;
      end
    end
  end
`ifdef RX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      good_cnt <= 16'h0;
      bad_cnt <= 16'h0;
    end else if (rep) begin
      if (r_status == 5'd0) good_cnt <= good_cnt + {15'd0, good_cnt != 16'hffff};
      else bad_cnt <= bad_cnt + {15'd0, bad_cnt != 16'hffff};
    end
  end
`endif
endmodule
